// File: rtl/ones_count_arbiter.sv
// ones_count_arbiter: grants whole multi-beat jobs to NREQ requesters in
// round-robin order. It feeds the granted requester's 127-bit beats through
// one shared combinational ones counter, accumulates the per-beat counts, and
// returns the total with the requester id over a valid/ready result port.
module ones_count_arbiter #(
   parameter int unsigned NREQ     = 4,
   parameter int unsigned MAXBEATS = 8,
   parameter int unsigned IDW      = $clog2(NREQ),
   parameter int unsigned ACCW     = 7 + $clog2(MAXBEATS)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NREQ-1:0]       req_valid,
   input  logic [NREQ-1:0]       req_last,
   input  logic [NREQ*127-1:0]   req_data,
   output logic [NREQ-1:0]       req_ready,
   output logic                  res_valid,
   input  logic                  res_ready,
   output logic [ACCW-1:0]       res_count,
   output logic [IDW-1:0]        res_id,
   output logic                  res_trunc
);

   localparam int unsigned DW  = 127;
   // One extra bit so the counter can represent MAXBEATS itself.
   localparam int unsigned BCW = $clog2(MAXBEATS) + 1;

   typedef enum logic [1:0] {
      StIdle,
      StGrant,
      StBusy,
      StDone
   } state_e;

   state_e           state_q, state_d;
   logic [IDW-1:0]   gnt_q, gnt_d;
   logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
   logic [ACCW-1:0]  acc_q, acc_d;
   logic [BCW-1:0]   beat_cnt_q, beat_cnt_d;
   logic             trunc_q, trunc_d;

   logic             pick_found;
   logic [IDW-1:0]   pick_idx;
   logic [IDW-1:0]   cand;
   logic [DW-1:0]    slice;
   logic [6:0]       beat_ones;
   logic             beat_acc;
   logic             last_beat;
   logic             cap_beat;

   // OC127 ones counter; result range 0..127 fits in 7 bits.
   function automatic logic [6:0] popcount127(input logic [DW-1:0] v);
      logic [6:0] s;
      s = '0;
      for (int unsigned i = 0; i < DW; i++) begin
         s = s + 7'(v[i]);
      end
      return s;
   endfunction

   // Round-robin pick: first valid requester at or after rr_ptr, wrapping.
   always_comb begin
      pick_found = 1'b0;
      pick_idx   = '0;
      cand       = '0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         cand = IDW'((32'(rr_ptr_q) + k) % NREQ);
         if (!pick_found && req_valid[cand]) begin
            pick_found = 1'b1;
            pick_idx   = cand;
         end
      end
   end

   // Select the granted requester's beat as the ones counter input.
   always_comb begin
      slice = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (gnt_q == IDW'(i)) begin
            slice = req_data[i*DW +: DW];
         end
      end
   end

   // Beat handshake terms for the granted requester.
   always_comb begin
      beat_ones = popcount127(slice);
      beat_acc  = (state_q == StBusy) && req_valid[gnt_q];
      last_beat = req_last[gnt_q];
      // This accept is beat number MAXBEATS of the job.
      cap_beat  = (beat_cnt_q == BCW'(MAXBEATS - 1));
   end

   // Next-state logic for the job FSM and its datapath registers.
   always_comb begin
      state_d    = state_q;
      gnt_d      = gnt_q;
      rr_ptr_d   = rr_ptr_q;
      acc_d      = acc_q;
      beat_cnt_d = beat_cnt_q;
      trunc_d    = trunc_q;

      unique case (state_q)
         StIdle: begin
            if (pick_found) begin
               gnt_d   = pick_idx;
               state_d = StGrant;
            end
         end

         StGrant: begin
            acc_d      = '0;
            beat_cnt_d = '0;
            trunc_d    = 1'b0;
            state_d    = StBusy;
         end

         StBusy: begin
            if (beat_acc) begin
               acc_d      = acc_q + ACCW'(beat_ones);
               beat_cnt_d = beat_cnt_q + 1'b1;
               if (last_beat) begin
                  trunc_d = 1'b0;
                  state_d = StDone;
               end else if (cap_beat) begin
                  // Remaining beats of this requester become a later job.
                  trunc_d = 1'b1;
                  state_d = StDone;
               end
            end
         end

         StDone: begin
            if (res_ready) begin
               rr_ptr_d = (gnt_q == IDW'(NREQ - 1)) ? '0 : gnt_q + 1'b1;
               state_d  = StIdle;
            end
         end

         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // Outputs decode from state and registered job data only.
   always_comb begin
      req_ready = '0;
      if (state_q == StBusy) begin
         req_ready[gnt_q] = 1'b1;
      end
      res_valid = (state_q == StDone);
      res_count = acc_q;
      res_id    = gnt_q;
      res_trunc = trunc_q;
   end

   // State register with synchronous reset; reset drops any job in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StIdle;
         gnt_q      <= '0;
         rr_ptr_q   <= '0;
         acc_q      <= '0;
         beat_cnt_q <= '0;
         trunc_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         gnt_q      <= gnt_d;
         rr_ptr_q   <= rr_ptr_d;
         acc_q      <= acc_d;
         beat_cnt_q <= beat_cnt_d;
         trunc_q    <= trunc_d;
      end
   end

   a_ready_onehot : assert property (@(posedge clk) disable iff (rst) $onehot0(req_ready));

   a_result_stable : assert property (@(posedge clk) disable iff (rst)
      (res_valid && !res_ready) |=>
         (res_valid && $stable(res_count) && $stable(res_id) && $stable(res_trunc)));

endmodule

// File: tb/tb_ones_count_arbiter.sv
// Bench for ones_count_arbiter: per-requester beat lists drive the ports, a
// job-level scoreboard predicts each result from the accepted beats, and
// directed literal expectations pin the scoreboard for each scenario.
module tb_ones_count_arbiter;

   localparam int NREQ     = 4;
   localparam int MAXBEATS = 8;
   localparam int IDW      = 2;
   localparam int ACCW     = 10;
   localparam int DW       = 127;
   localparam int SLOTS    = 32;

   logic                 clk;
   logic                 rst;
   logic [NREQ-1:0]      req_valid;
   logic [NREQ-1:0]      req_last;
   logic [NREQ*DW-1:0]   req_data;
   logic [NREQ-1:0]      req_ready;
   logic                 res_valid;
   logic                 res_ready;
   logic [ACCW-1:0]      res_count;
   logic [IDW-1:0]       res_id;
   logic                 res_trunc;

   ones_count_arbiter #(
      .NREQ     (NREQ),
      .MAXBEATS (MAXBEATS)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_last  (req_last),
      .req_data  (req_data),
      .req_ready (req_ready),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_count (res_count),
      .res_id    (res_id),
      .res_trunc (res_trunc)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int tests = 0;
   int fails = 0;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
      end
   endtask

   // Stimulus: per-requester beat lists
   logic [DW-1:0]   bdata [NREQ][SLOTS];
   logic            blast [NREQ][SLOTS];
   int              bn [NREQ];
   int              bi [NREQ];
   logic [NREQ-1:0] hold;

   function automatic logic [DW-1:0] ones(input int n, input bit hi);
      logic [DW-1:0] v;
      v = '0;
      for (int i = 0; i < n; i++) begin
         if (hi) v[DW-1-i] = 1'b1;
         else    v[i] = 1'b1;
      end
      return v;
   endfunction

   task automatic add_beat(input int r, input logic [DW-1:0] d, input logic l);
      if (bn[r] < SLOTS) begin
         bdata[r][bn[r]] = d;
         blast[r][bn[r]] = l;
         bn[r]++;
      end
   endtask

   task automatic clear_stim();
      for (int r = 0; r < NREQ; r++) begin
         bn[r] = 0;
         bi[r] = 0;
      end
   endtask

   function automatic bit all_consumed();
      for (int r = 0; r < NREQ; r++) begin
         if (bi[r] < bn[r]) return 1'b0;
      end
      return 1'b1;
   endfunction

   // Scoreboard / model state
   logic [NREQ-1:0] acc_mask = '0;
   int cur_owner = -1;
   int cur_sum   = 0;
   int cur_beats = 0;
   int exp_cnt[$];
   int exp_id[$];
   int exp_tr[$];
   int log_cnt[$];
   int log_id[$];
   int log_tr[$];
   int cyc = 0;
   int valid_start = 0;
   int last_lat = -1;
   int run0 = 0;
   int max_run0 = 0;
   bit prev_rst = 1'b0;
   bit prev_stall = 1'b0;
   bit prev_res_valid = 1'b0;
   bit prev_any_valid = 1'b0;
   logic [ACCW-1:0] prev_count = '0;
   logic [IDW-1:0]  prev_id = '0;
   logic            prev_trunc = 1'b0;

   // Driver: advance on accepted beats and present the next one, 1 after the edge
   initial begin
      forever begin
         @(posedge clk);
         #1;
         for (int r = 0; r < NREQ; r++) begin
            if (acc_mask[r]) bi[r]++;
         end
         for (int r = 0; r < NREQ; r++) begin
            if (bi[r] < bn[r] && !hold[r]) begin
               req_valid[r]            = 1'b1;
               req_last[r]             = blast[r][bi[r]];
               req_data[r*DW +: DW]    = bdata[r][bi[r]];
            end else begin
               req_valid[r]            = 1'b0;
               req_last[r]             = 1'b0;
               req_data[r*DW +: DW]    = '0;
            end
         end
      end
   end

   // Compare process: checks outputs every cycle at the falling edge
   initial begin
      forever begin
         @(negedge clk);
         cyc++;
         if (prev_rst)
            check("reset_outputs", {req_ready, res_valid, res_count, res_id, res_trunc}, 0);
         check("ready_onehot0", 64'($onehot0(req_ready)), 1);
         if (res_valid) check("no_ready_in_done", req_ready, 0);
         if (prev_stall) begin
            check("stall_valid", res_valid, 1);
            check("stall_count", res_count, prev_count);
            check("stall_id", res_id, prev_id);
            check("stall_trunc", res_trunc, prev_trunc);
         end
         if (!prev_any_valid && req_valid != '0) valid_start = cyc;
         if (res_valid && !prev_res_valid && !prev_rst) last_lat = cyc - valid_start;
         if (req_ready[0]) run0++;
         else run0 = 0;
         if (run0 > max_run0) max_run0 = run0;

         if (rst) begin
            acc_mask  = '0;
            cur_owner = -1;
            cur_sum   = 0;
            cur_beats = 0;
            exp_cnt.delete();
            exp_id.delete();
            exp_tr.delete();
         end else begin
            acc_mask = req_valid & req_ready;
            for (int i = 0; i < NREQ; i++) begin
               if (acc_mask[i]) begin
                  if (cur_owner < 0) cur_owner = i;
                  else check("job_owner", i, cur_owner);
                  cur_sum += $countones(req_data[i*DW +: DW]);
                  cur_beats++;
                  if (req_last[i] || cur_beats == MAXBEATS) begin
                     exp_cnt.push_back(cur_sum);
                     exp_id.push_back(i);
                     exp_tr.push_back(req_last[i] ? 0 : 1);
                     cur_owner = -1;
                     cur_sum   = 0;
                     cur_beats = 0;
                  end
               end
            end
            if (res_valid && res_ready) begin
               check("result_expected", 64'(exp_cnt.size() != 0), 1);
               if (exp_cnt.size() != 0) begin
                  check("res_count", res_count, exp_cnt.pop_front());
                  check("res_id", res_id, exp_id.pop_front());
                  check("res_trunc", res_trunc, exp_tr.pop_front());
               end
               log_cnt.push_back(int'(res_count));
               log_id.push_back(int'(res_id));
               log_tr.push_back(int'(res_trunc));
            end
         end
         prev_rst       = rst;
         prev_stall     = res_valid && !res_ready && !rst;
         prev_count     = res_count;
         prev_id        = res_id;
         prev_trunc     = res_trunc;
         prev_res_valid = res_valid;
         prev_any_valid = (req_valid != '0);
      end
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic do_reset();
      step();
      rst  = 1'b1;
      hold = '1;
      step();
      step();
      clear_stim();
      rst = 1'b0;
      step();
      hold     = '0;
      max_run0 = 0;
      run0     = 0;
   endtask

   task automatic wait_drain(input int budget);
      bit done;
      done = 1'b0;
      for (int k = 0; k < budget && !done; k++) begin
         step();
         done = all_consumed() && cur_owner < 0 && exp_cnt.size() == 0 && !res_valid;
      end
      check("drain_done", 64'(done), 1);
   endtask

   task automatic wait_beats(input int r, input int n, input int budget);
      bit ok;
      ok = 1'b0;
      for (int k = 0; k < budget && !ok; k++) begin
         step();
         ok = (bi[r] >= n);
      end
      check("beats_reached", 64'(ok), 1);
   endtask

   task automatic wait_res(input int budget);
      bit ok;
      ok = 1'b0;
      for (int k = 0; k < budget && !ok; k++) begin
         step();
         ok = res_valid;
      end
      check("res_seen", 64'(ok), 1);
   endtask

   task automatic check_log(input string nm, input int idx, input int c, input int id,
                            input int tr);
      check({nm, "_present"}, 64'(log_cnt.size() > idx), 1);
      if (log_cnt.size() > idx) begin
         check({nm, "_count"}, log_cnt[idx], c);
         check({nm, "_id"}, log_id[idx], id);
         check({nm, "_trunc"}, log_tr[idx], tr);
      end
   endtask

   initial begin
      int base;
      rst       = 1'b1;
      hold      = '1;
      res_ready = 1'b1;
      req_valid = '0;
      req_last  = '0;
      req_data  = '0;
      clear_stim();
      repeat (3) step();
      rst  = 1'b0;
      hold = '0;

      // Single one-beat job from requester 2
      do_reset();
      base = log_cnt.size();
      add_beat(2, ones(127, 1'b0), 1'b1);
      wait_drain(50);
      check("single_latency", last_lat, 3);
      check_log("single", base, 127, 2, 0);

      // Three back-to-back beats from requester 0
      do_reset();
      base = log_cnt.size();
      add_beat(0, ones(5, 1'b1), 1'b0);
      add_beat(0, ones(0, 1'b0), 1'b0);
      add_beat(0, ones(127, 1'b0), 1'b1);
      wait_drain(50);
      check("multi_ready_run", max_run0, 3);
      check_log("multi", base, 132, 0, 0);

      // Round-robin with all four requesters busy
      do_reset();
      base = log_cnt.size();
      for (int r = 0; r < NREQ; r++) begin
         add_beat(r, ones(r + 1, 1'b0), 1'b1);
         add_beat(r, ones(r + 11, 1'b1), 1'b1);
      end
      wait_drain(200);
      check_log("rr0", base + 0, 1, 0, 0);
      check_log("rr1", base + 1, 2, 1, 0);
      check_log("rr2", base + 2, 3, 2, 0);
      check_log("rr3", base + 3, 4, 3, 0);
      check_log("rr4", base + 4, 11, 0, 0);

      // Truncation at MAXBEATS, remainder as a new job
      do_reset();
      base = log_cnt.size();
      for (int b = 0; b < 10; b++) add_beat(1, ones(127, 1'b0), (b == 9));
      wait_drain(200);
      check_log("trunc_first", base, 1016, 1, 1);
      check_log("trunc_rest", base + 1, 254, 1, 0);

      // Valid gap mid-job, then result backpressure
      do_reset();
      base = log_cnt.size();
      add_beat(2, ones(10, 1'b0), 1'b0);
      add_beat(2, ones(20, 1'b1), 1'b0);
      add_beat(2, ones(30, 1'b0), 1'b0);
      add_beat(2, ones(40, 1'b1), 1'b1);
      wait_beats(2, 2, 50);
      add_beat(0, ones(7, 1'b0), 1'b1);
      hold[2] = 1'b1;
      repeat (4) step();
      hold[2]   = 1'b0;
      res_ready = 1'b0;
      wait_res(50);
      repeat (5) step();
      res_ready = 1'b1;
      wait_drain(100);
      check_log("gap_job", base, 100, 2, 0);
      check_log("after_stall", base + 1, 7, 0, 0);

      // Reset while busy after two beats
      do_reset();
      for (int b = 0; b < 4; b++) add_beat(1, ones(3, 1'b0), (b == 3));
      wait_beats(1, 2, 50);
      rst  = 1'b1;
      hold = '1;
      step();
      rst = 1'b0;
      clear_stim();
      step();
      hold = '0;
      base = log_cnt.size();
      add_beat(3, ones(9, 1'b0), 1'b0);
      add_beat(3, ones(6, 1'b1), 1'b1);
      wait_drain(100);
      check("reset_one_result", log_cnt.size(), base + 1);
      check_log("post_reset", base, 15, 3, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
      $fatal(1, "watchdog");
   end

endmodule
